// File: rtl/seq_sreg_pkg.sv
// seq_sreg_pkg -- shared types and helpers for the seq_sreg_sipo_deser slice.
//   state_t   : deserialiser FSM states (FILL gathers bits, FULL presents a word)
//   cnt_width : width of a counter that must hold the values 0..frame
package seq_sreg_pkg;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  // Bits needed to count 0..frame inclusive.
  function automatic int cnt_width(input int frame);
    return $clog2(frame + 1);
  endfunction

endpackage

// File: rtl/seq_sreg_bitcnt.sv
// seq_sreg_bitcnt -- frame bit counter for the SIPO deserialiser.
// Counts accepted bits 0..FRAME-1. Controls in priority order:
//   clr   : return to 0 (last bit of a frame accepted)
//   load1 : jump to 1 (handoff cycle, the accepted bit is bit 0 of a new frame)
//   inc   : advance by one
// last flags that the next accepted bit closes the frame.
module seq_sreg_bitcnt
  import seq_sreg_pkg::*;
#(
  parameter  int FRAME = 8,
  localparam int CW    = cnt_width(FRAME)
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  input  logic load1,
  output logic last
);

  logic [CW-1:0] cnt;

  // Counter register; clear wins over load-1, which wins over increment.
  // NOTE: every flop in this slice resets asynchronously and is assigned with <=
  // so all registers update together from values sampled before the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load1) begin
      cnt <= CW'(1);
    end else if (inc) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign last = (cnt == CW'(FRAME - 1));

endmodule

// File: rtl/seq_sreg_sipo_deser.sv
// seq_sreg_sipo_deser -- parametrised serial-in/parallel-out deserialiser.
// Gathers NBITS serial bits under an in_val/in_rdy handshake (MSB- or
// LSB-first) and presents the word on an out_val/out_rdy port with
// backpressure and zero-bubble back-to-back framing.
//
// Optional feature macro: SEQ_SREG_SIPO_PARITY_EN
//   defined   : each frame is NBITS data bits plus one even-parity bit; the
//               parity bit is not stored in pout and out_perr reports
//               XOR(data bits, parity bit), registered on the parity-bit edge.
//   undefined : frame is NBITS bits and the out_perr port does not exist.
module seq_sreg_sipo_deser
  import seq_sreg_pkg::*;
#(
  parameter int NBITS     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic             sin,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [NBITS-1:0] pout
`ifdef SEQ_SREG_SIPO_PARITY_EN
  ,
  output logic             out_perr
`endif
);

`ifdef SEQ_SREG_SIPO_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int FRAME = NBITS + PAR_BITS;

  // A one-bit word would make the shift slices below degenerate.
  if (NBITS < 2) begin : g_bad_nbits
    $error("seq_sreg_sipo_deser: NBITS must be >= 2");
  end

  state_t           state;
  state_t           state_nxt;
  logic [NBITS-1:0] sreg;
  logic             accept;
  logic             shift_en;
  logic             cnt_inc;
  logic             cnt_clr;
  logic             cnt_load1;
  logic             last;
  logic             parity_bit;

  seq_sreg_bitcnt #(
    .FRAME (FRAME)
  ) u_bitcnt (
    .clk   (clk),
    .reset (reset),
    .inc   (cnt_inc),
    .clr   (cnt_clr),
    .load1 (cnt_load1),
    .last  (last)
  );

  // With parity enabled the closing bit of a frame (seen in FILL) is the
  // parity bit and must not enter the shift register.
`ifdef SEQ_SREG_SIPO_PARITY_EN
  assign parity_bit = (state == FILL) && last;
`else
  assign parity_bit = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, handshake outputs and counter controls.
  // NOTE: every output of this block gets a default first so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    in_rdy    = 1'b1;
    out_val   = 1'b0;
    accept    = 1'b0;
    cnt_inc   = 1'b0;
    cnt_clr   = 1'b0;
    cnt_load1 = 1'b0;
    unique case (state)
      FILL: begin
        in_rdy = 1'b1;
        accept = in_val;
        if (accept) begin
          if (last) begin
            cnt_clr   = 1'b1;
            state_nxt = FULL;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      FULL: begin
        // The consumer's ready passes straight through: a bit may only be
        // taken in the same cycle the held word is handed off.
        in_rdy  = out_rdy;
        out_val = 1'b1;
        accept  = in_val && out_rdy;
        if (out_rdy) begin
          state_nxt = FILL;
          if (accept) begin
            cnt_load1 = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = FILL;
      end
    endcase
  end

  assign shift_en = accept && !parity_bit;

  // Shift register: each accepted data bit enters at the configured end.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sreg <= '0;
    end else if (shift_en) begin
      if (MSB_FIRST) begin
        sreg <= {sreg[NBITS-2:0], sin};
      end else begin
        sreg <= {sin, sreg[NBITS-1:1]};
      end
    end
  end

  assign pout = sreg;

`ifdef SEQ_SREG_SIPO_PARITY_EN
  logic par_acc;

  // Parity accumulator over the data bits; on the parity bit the error flag
  // captures the full XOR and the accumulator restarts for the next frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_acc  <= 1'b0;
      out_perr <= 1'b0;
    end else if (accept) begin
      if (parity_bit) begin
        out_perr <= par_acc ^ sin;
        par_acc  <= 1'b0;
      end else begin
        par_acc <= par_acc ^ sin;
      end
    end
  end
`endif

endmodule

// File: tb/tb_seq_sreg_sipo_deser.sv
// tb_seq_sreg_sipo_deser -- self-checking bench for seq_sreg_sipo_deser.
// Two DUTs (MSB_FIRST=1 and MSB_FIRST=0) share the same stimulus. A bench
// model builds the expected words as bits are accepted and pushes them to
// scoreboard queues; a negedge monitor pops and compares on every handoff.
// Honours SEQ_SREG_SIPO_PARITY_EN in the same way as the design.
module tb_seq_sreg_sipo_deser;

  localparam int NBITS = 8;
`ifdef SEQ_SREG_SIPO_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FRAME = NBITS + PAR;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_val;
  logic             sin;
  logic             out_rdy;
  logic             in_rdy_m, out_val_m, in_rdy_l, out_val_l;
  logic [NBITS-1:0] pout_m, pout_l;
`ifdef SEQ_SREG_SIPO_PARITY_EN
  logic             perr_m, perr_l;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_sreg_sipo_deser #(.NBITS(NBITS), .MSB_FIRST(1'b1)) dut_m (
    .clk      (clk),
    .reset    (reset),
    .in_val   (in_val),
    .in_rdy   (in_rdy_m),
    .sin      (sin),
    .out_val  (out_val_m),
    .out_rdy  (out_rdy),
    .pout     (pout_m)
`ifdef SEQ_SREG_SIPO_PARITY_EN
    ,
    .out_perr (perr_m)
`endif
  );

  seq_sreg_sipo_deser #(.NBITS(NBITS), .MSB_FIRST(1'b0)) dut_l (
    .clk      (clk),
    .reset    (reset),
    .in_val   (in_val),
    .in_rdy   (in_rdy_l),
    .sin      (sin),
    .out_val  (out_val_l),
    .out_rdy  (out_rdy),
    .pout     (pout_l)
`ifdef SEQ_SREG_SIPO_PARITY_EN
    ,
    .out_perr (perr_l)
`endif
  );

  // ---------------- bench model and scoreboard ----------------
  logic [NBITS-1:0] exp_m_q[$];
  logic [NBITS-1:0] exp_l_q[$];
  logic             exp_p_q[$];
  int               bit_idx = 0;
  logic [NBITS-1:0] acc_m = '0;
  logic [NBITS-1:0] acc_l = '0;
  logic             acc_p = 1'b0;

  task automatic model_reset();
    bit_idx = 0;
    acc_m   = '0;
    acc_l   = '0;
    acc_p   = 1'b0;
  endtask

  task automatic model_bit(input logic b);
    if (bit_idx < NBITS) begin
      acc_m          = {acc_m[NBITS-2:0], b};
      acc_l[bit_idx] = b;
    end
    acc_p   = acc_p ^ b;
    bit_idx = bit_idx + 1;
    if (bit_idx == FRAME) begin
      exp_m_q.push_back(acc_m);
      exp_l_q.push_back(acc_l);
      exp_p_q.push_back(acc_p);
      bit_idx = 0;
      acc_p   = 1'b0;
    end
  endtask

  logic [NBITS-1:0] mon_m, mon_l;
  logic             mon_p;

  // Handoff monitor: every word taken by the consumer must match the model.
  always @(negedge clk) begin
    if (!reset && out_rdy) begin
      if (out_val_m) begin
        checks++;
        if (exp_m_q.size() == 0) begin
          errors++;
          $display("FAIL sb_msb unexpected word got=%h expected=none", pout_m);
        end else begin
          mon_m = exp_m_q.pop_front();
          mon_p = exp_p_q.pop_front();
          if (pout_m !== mon_m) begin
            errors++;
            $display("FAIL sb_msb got=%h expected=%h", pout_m, mon_m);
          end
`ifdef SEQ_SREG_SIPO_PARITY_EN
          checks++;
          if (perr_m !== mon_p) begin
            errors++;
            $display("FAIL sb_perr got=%b expected=%b", perr_m, mon_p);
          end
`endif
        end
      end
      if (out_val_l) begin
        checks++;
        if (exp_l_q.size() == 0) begin
          errors++;
          $display("FAIL sb_lsb unexpected word got=%h expected=none", pout_l);
        end else begin
          mon_l = exp_l_q.pop_front();
          if (pout_l !== mon_l) begin
            errors++;
            $display("FAIL sb_lsb got=%h expected=%h", pout_l, mon_l);
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // One cycle: drive after the edge, sample the handshake at the negedge.
  task automatic cycle(input logic v, input logic b, input logic r, output logic acc);
    in_val  = v;
    sin     = b;
    out_rdy = r;
    @(negedge clk);
    acc = v && in_rdy_m;
    if (acc) model_bit(b);
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic r);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 20) begin
      cycle(1'b1, b, r, acc);
      n++;
    end
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL send_bit_timeout got=no_accept expected=accept within 20 cycles");
    end
  endtask

  task automatic send_word(input logic [NBITS-1:0] w, input logic pbit, input logic r);
    for (int i = NBITS - 1; i >= 0; i--) send_bit(w[i], r);
    if (PAR == 1) send_bit(pbit, r);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset   = 1'b1;
    in_val  = 1'b0;
    sin     = 1'b0;
    out_rdy = 1'b1;
    #1;
    checks++;
    if (pout_m !== '0 || out_val_m !== 1'b0) begin
      errors++;
      $display("FAIL reset_values got pout=%h out_val=%b expected pout=00 out_val=0", pout_m, out_val_m);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (in_rdy_m !== 1'b1 || out_val_l !== 1'b0 || pout_l !== '0) begin
      errors++;
      $display("FAIL reset_release got in_rdy=%b out_val=%b pout=%h expected 1 0 00", in_rdy_m, out_val_l, pout_l);
    end
`ifdef SEQ_SREG_SIPO_PARITY_EN
    checks++;
    if (perr_m !== 1'b0) begin
      errors++;
      $display("FAIL reset_perr got=%b expected=0", perr_m);
    end
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic test_msb_lsb();
    send_word(8'hB2, ^8'hB2, 1'b1);
    in_val  = 1'b0;
    out_rdy = 1'b1;
    @(negedge clk);
    checks++;
    if (out_val_m !== 1'b1 || pout_m !== 8'hB2) begin
      errors++;
      $display("FAIL msb_word got val=%b pout=%h expected val=1 pout=b2", out_val_m, pout_m);
    end
    checks++;
    if (out_val_l !== 1'b1 || pout_l !== 8'h4D) begin
      errors++;
      $display("FAIL lsb_word got val=%b pout=%h expected val=1 pout=4d", out_val_l, pout_l);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (out_val_m !== 1'b0) begin
      errors++;
      $display("FAIL single_pulse got out_val=%b expected=0", out_val_m);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    send_word(8'hB2, ^8'hB2, 1'b0);
    for (int k = 0; k < 3; k++) begin
      in_val  = 1'b1;
      sin     = k[0];
      out_rdy = 1'b0;
      @(negedge clk);
      checks++;
      if (in_rdy_m !== 1'b0 || out_val_m !== 1'b1 || pout_m !== 8'hB2) begin
        errors++;
        $display("FAIL backpressure_hold cyc=%0d got in_rdy=%b out_val=%b pout=%h expected 0 1 b2",
                 k, in_rdy_m, out_val_m, pout_m);
      end
      @(posedge clk);
      #1;
    end
    in_val  = 1'b0;
    out_rdy = 1'b1;
    @(negedge clk);
    checks++;
    if (out_val_m !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_release got out_val=%b expected=1", out_val_m);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (out_val_m !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_done got out_val=%b expected=0", out_val_m);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    logic [NBITS-1:0] words[3];
    logic             bits[$];
    int               pulses;
    int               stalls;
    words[0] = 8'hB2;
    words[1] = 8'h5A;
    words[2] = 8'hC3;
    for (int w = 0; w < 3; w++) begin
      for (int i = NBITS - 1; i >= 0; i--) bits.push_back(words[w][i]);
      if (PAR == 1) bits.push_back(^words[w]);
    end
    pulses = 0;
    stalls = 0;
    foreach (bits[i]) begin
      in_val  = 1'b1;
      sin     = bits[i];
      out_rdy = 1'b1;
      @(negedge clk);
      if (!in_rdy_m) stalls++;
      if (out_val_m) pulses++;
      if (in_rdy_m) model_bit(bits[i]);
      @(posedge clk);
      #1;
    end
    in_val = 1'b0;
    @(negedge clk);
    if (out_val_m) pulses++;
    @(posedge clk);
    #1;
    checks++;
    if (stalls != 0) begin
      errors++;
      $display("FAIL b2b_stalls got=%0d expected=0", stalls);
    end
    checks++;
    if (pulses != 3) begin
      errors++;
      $display("FAIL b2b_pulses got=%0d expected=3", pulses);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [4:0] part;
    part    = 5'b10110;
    out_rdy = 1'b1;
    for (int i = 4; i >= 0; i--) send_bit(part[i], 1'b1);
    in_val = 1'b0;
    checks++;
    if (pout_m !== acc_m) begin
      errors++;
      $display("FAIL partial_word got=%h expected=%h", pout_m, acc_m);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (pout_m !== '0 || pout_l !== '0 || out_val_m !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got pout_m=%h pout_l=%h out_val=%b expected 00 00 0",
               pout_m, pout_l, out_val_m);
    end
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    send_word(8'hB2, ^8'hB2, 1'b1);
    in_val = 1'b0;
    @(negedge clk);
    checks++;
    if (out_val_m !== 1'b1 || pout_m !== 8'hB2) begin
      errors++;
      $display("FAIL after_reset_word got val=%b pout=%h expected val=1 pout=b2", out_val_m, pout_m);
    end
    @(posedge clk);
    #1;
  endtask

`ifdef SEQ_SREG_SIPO_PARITY_EN
  task automatic test_parity();
    logic pexp[2];
    pexp[0] = 1'b0;
    pexp[1] = 1'b1;
    for (int t = 0; t < 2; t++) begin
      send_word(8'hB2, pexp[t], 1'b1);
      in_val  = 1'b0;
      out_rdy = 1'b1;
      @(negedge clk);
      checks++;
      if (out_val_m !== 1'b1 || perr_m !== pexp[t] || pout_m !== 8'hB2) begin
        errors++;
        $display("FAIL parity_%0d got val=%b perr=%b pout=%h expected val=1 perr=%b pout=b2",
                 t, out_val_m, perr_m, pout_m, pexp[t]);
      end
      @(posedge clk);
      #1;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_msb_lsb();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef SEQ_SREG_SIPO_PARITY_EN
    test_parity();
`endif
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (exp_m_q.size() != 0 || exp_l_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got pending msb=%0d lsb=%0d expected 0 0", exp_m_q.size(), exp_l_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
